// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS+FPU main control FSM with memory wait states,
// FPU start/done handshake with timeout, and sticky exception cause.
module multicycle_control #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit FP_EN       = 1'b1,
   parameter int FPU_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] instr_op,
   input  logic [5:0] instr_funct,
   input  logic       mem_ready,
   input  logic       fpu_done,
   input  logic       exc_clear,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [2:0] alu_ctl,
   output logic       fpo,
   output logic       fpu_start,
   output logic [1:0] exc_cause,
   output logic [3:0] state_dbg
);
   localparam int CW = $clog2(FPU_TIMEOUT + 1);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB,
      I_EXEC, I_WB, BRANCH, JUMP, FP_EXEC, FP_WAIT, FP_WB, TRAP
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_ctl;
      logic       fpo;
      logic       fpu_start;
   } ctl_t;

   state_t        state_q, state_d;
   logic [1:0]    exc_cause_q, exc_cause_d, cause_q, cause_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fp_q, fp_d, store_q, store_d;
   logic          rdy, funct_ok, fp_mem;
   logic [2:0]    funct_alu;
   ctl_t          c;

   assign rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign fp_mem    = FP_EN && (instr_op == 6'b110001 || instr_op == 6'b111001);
   assign funct_ok  = instr_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   assign funct_alu = instr_funct == 6'b100000 ? 3'b010 :
                      instr_funct == 6'b100010 ? 3'b110 :
                      instr_funct == 6'b100100 ? 3'b000 :
                      instr_funct == 6'b100101 ? 3'b001 : 3'b111;

   always_comb begin
      state_d     = state_q;
      exc_cause_d = exc_clear ? 2'b00 : exc_cause_q;
      cause_d     = cause_q;
      cnt_d       = cnt_q;
      fp_d        = fp_q;
      store_d     = store_q;
      c           = '0;
      case (state_q)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.alu_ctl   = 3'b010;
            c.ir_write  = rdy;
            c.pc_write  = rdy;
            state_d     = rdy ? DECODE : FETCH;
         end
         DECODE: begin
            c.alu_src_b = 2'b10;
            c.alu_ctl   = 3'b010;
            fp_d        = fp_mem || (FP_EN && instr_op == 6'b010001);
            store_d     = instr_op[3];
            cause_d     = 2'b01;
            case (instr_op)
               6'b000000: begin
                  state_d = funct_ok ? R_EXEC : TRAP;
                  cause_d = 2'b11;
               end
               6'b001000:            state_d = I_EXEC;
               6'b100011, 6'b101011: state_d = MEM_ADDR;
               6'b110001, 6'b111001: state_d = FP_EN ? MEM_ADDR : TRAP;
               6'b000100:            state_d = BRANCH;
               6'b000010:            state_d = JUMP;
               6'b010001:            state_d = FP_EN ? FP_EXEC : TRAP;
               default:              state_d = TRAP;
            endcase
         end
         MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_ctl   = 3'b010;
            c.fpo       = fp_q;
            state_d     = store_q ? MEM_WRITE : MEM_READ;
         end
         MEM_READ: begin
            c.i_or_d   = 1'b1;
            c.mem_read = 1'b1;
            c.fpo      = fp_q;
            state_d    = rdy ? MEM_WB : MEM_READ;
         end
         MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.fpo        = fp_q;
            state_d      = FETCH;
         end
         MEM_WRITE: begin
            c.i_or_d    = 1'b1;
            c.mem_write = rdy;
            c.fpo       = fp_q;
            state_d     = rdy ? FETCH : MEM_WRITE;
         end
         R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_ctl   = funct_alu;
            state_d     = R_WB;
         end
         R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            state_d     = FETCH;
         end
         I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_ctl   = 3'b010;
            state_d     = I_WB;
         end
         I_WB: begin
            c.reg_write = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_ctl       = 3'b110;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            state_d         = FETCH;
         end
         JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
            state_d     = FETCH;
         end
         FP_EXEC: begin
            c.fpu_start = 1'b1;
            c.fpo       = 1'b1;
            cnt_d       = '0;
            state_d     = FP_WAIT;
         end
         FP_WAIT: begin
            c.fpo = 1'b1;
            // done is tested first so a late result beats the timeout
            if (fpu_done) state_d = FP_WB;
            else if (cnt_q == CW'(FPU_TIMEOUT - 1)) begin
               state_d = TRAP;
               cause_d = 2'b10;
            end else cnt_d = cnt_q + CW'(1);
         end
         FP_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            c.fpo       = 1'b1;
            state_d     = FETCH;
         end
         TRAP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b11;
            exc_cause_d = cause_q;
            state_d     = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH;
         exc_cause_q <= 2'b00;
         cause_q     <= 2'b00;
         cnt_q       <= '0;
         fp_q        <= 1'b0;
         store_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         exc_cause_q <= exc_cause_d;
         cause_q     <= cause_d;
         cnt_q       <= cnt_d;
         fp_q        <= fp_d;
         store_q     <= store_d;
      end
   end

   // FETCH decodes to nonzero strobes, so the controls are masked while in reset
   assign {pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, mem_to_reg, reg_dst,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_ctl, fpo, fpu_start} = rst_n ? c : '0;
   assign state_dbg = state_q;
   assign exc_cause = exc_cause_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: expands each instruction into its expected per-cycle control words
// from the instruction class and a random stall plan, then plays the plan into the DUT.
module tb_multicycle_control;
   localparam logic [18:0] PCW = 19'h40000, PCWC = 19'h20000, IOD = 19'h10000, IRW = 19'h08000,
                           MR = 19'h04000, MW = 19'h02000, M2R = 19'h01000, RD = 19'h00800,
                           RW = 19'h00400, ASA = 19'h00200, FPO = 19'h00002, FST = 19'h00001;

   typedef struct {
      logic        rdy, done, clr;
      logic [18:0] exp;
      logic [1:0]  exc;
   } ent_t;

   logic        clk = 1'b0, rst1_n = 1'b0, rst2_n = 1'b0, sel = 1'b0;
   logic [5:0]  instr_op = '0, instr_funct = '0;
   logic        mem_ready = 1'b0, fpu_done = 1'b0, exc_clear = 1'b0;
   logic [18:0] o1, o2, obs;
   logic [1:0]  exc1, exc2, exc_o;
   logic [3:0]  st1, st2, st_o;
   ent_t        q[$];
   int          total = 0, bad = 0, cause_m = 0, tmo = 16;
   bit          wen = 1'b1, fen = 1'b1, force_clr = 1'b0;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .rst_n(rst1_n), .instr_op(instr_op), .instr_funct(instr_funct),
      .mem_ready(mem_ready), .fpu_done(fpu_done), .exc_clear(exc_clear),
      .pc_write(o1[18]), .pc_write_cond(o1[17]), .i_or_d(o1[16]), .ir_write(o1[15]),
      .mem_read(o1[14]), .mem_write(o1[13]), .mem_to_reg(o1[12]), .reg_dst(o1[11]),
      .reg_write(o1[10]), .alu_src_a(o1[9]), .alu_src_b(o1[8:7]), .pc_source(o1[6:5]),
      .alu_ctl(o1[4:2]), .fpo(o1[1]), .fpu_start(o1[0]), .exc_cause(exc1), .state_dbg(st1)
   );

   multicycle_control #(.MEM_WAIT_EN(1'b0), .FP_EN(1'b0), .FPU_TIMEOUT(3)) dut2 (
      .clk(clk), .rst_n(rst2_n), .instr_op(instr_op), .instr_funct(instr_funct),
      .mem_ready(mem_ready), .fpu_done(fpu_done), .exc_clear(exc_clear),
      .pc_write(o2[18]), .pc_write_cond(o2[17]), .i_or_d(o2[16]), .ir_write(o2[15]),
      .mem_read(o2[14]), .mem_write(o2[13]), .mem_to_reg(o2[12]), .reg_dst(o2[11]),
      .reg_write(o2[10]), .alu_src_a(o2[9]), .alu_src_b(o2[8:7]), .pc_source(o2[6:5]),
      .alu_ctl(o2[4:2]), .fpo(o2[1]), .fpu_start(o2[0]), .exc_cause(exc2), .state_dbg(st2)
   );

   assign obs   = sel ? o2 : o1;
   assign exc_o = sel ? exc2 : exc1;
   assign st_o  = sel ? st2 : st1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [18:0] asb(input logic [1:0] v); return {10'b0, v, 7'b0}; endfunction
   function automatic logic [18:0] pcs(input logic [1:0] v); return {12'b0, v, 5'b0}; endfunction
   function automatic logic [18:0] alu(input logic [2:0] v); return {14'b0, v, 2'b0}; endfunction
   function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'd32:   return 3'b010;
         6'd34:   return 3'b110;
         6'd36:   return 3'b000;
         6'd37:   return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   // Each entry: inputs for one cycle, the controls expected then, and the cause visible then.
   task automatic push(input logic r, input logic d, input logic [18:0] x, input int tc);
      ent_t e;
      e.rdy = r; e.done = d; e.exp = x; e.exc = 2'(cause_m);
      e.clr = force_clr ? 1'b1 : ($urandom_range(0, 7) == 0);
      force_clr = 1'b0;
      q.push_back(e);
      if (tc != 0) cause_m = tc;
      else if (e.clr) cause_m = 0;
   endtask

   task automatic gen(input logic [5:0] op, input logic [5:0] f, input int fw, input int mw, input int fn);
      logic [18:0] fx;
      bit fpm;
      fpm = fen && (op == 6'b110001 || op == 6'b111001);
      fx  = fpm ? FPO : 19'h0;
      if (wen) repeat (fw) push(1'b0, rb(), MR | asb(2'b01) | alu(3'b010), 0);
      push(wen ? 1'b1 : rb(), rb(), MR | asb(2'b01) | alu(3'b010) | IRW | PCW, 0);
      push(rb(), rb(), asb(2'b10) | alu(3'b010), 0);
      if (op == 6'b000000) begin
         if (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42}) begin
            push(rb(), rb(), ASA | alu(r_alu(f)), 0);
            push(rb(), rb(), RW | RD, 0);
         end else push(rb(), rb(), PCW | pcs(2'b11), 3);
      end else if (op == 6'b001000) begin
         push(rb(), rb(), ASA | asb(2'b10) | alu(3'b010), 0);
         push(rb(), rb(), RW, 0);
      end else if (op == 6'b100011 || op == 6'b101011 || fpm) begin
         push(rb(), rb(), ASA | asb(2'b10) | alu(3'b010) | fx, 0);
         if (!op[3]) begin
            if (wen) repeat (mw) push(1'b0, rb(), IOD | MR | fx, 0);
            push(wen ? 1'b1 : rb(), rb(), IOD | MR | fx, 0);
            push(rb(), rb(), RW | M2R | fx, 0);
         end else begin
            if (wen) repeat (mw) push(1'b0, rb(), IOD | fx, 0);
            push(wen ? 1'b1 : rb(), rb(), IOD | MW | fx, 0);
         end
      end else if (op == 6'b000100) push(rb(), rb(), ASA | alu(3'b110) | PCWC | pcs(2'b01), 0);
      else if (op == 6'b000010) push(rb(), rb(), PCW | pcs(2'b10), 0);
      else if (op == 6'b010001 && fen) begin
         push(rb(), rb(), FST | FPO, 0);
         for (int i = 1; i <= fn && i <= tmo; i++) push(rb(), 1'(i == fn), FPO, 0);
         if (fn <= tmo) push(rb(), rb(), RW | RD | FPO, 0);
         else push(rb(), rb(), PCW | pcs(2'b11), 2);
      end else push(rb(), rb(), PCW | pcs(2'b11), 1);
   endtask

   // Called at posedge+1; leaves at posedge+1 after the last played cycle.
   task automatic play(input int n);
      ent_t e;
      int k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         e = q.pop_front();
         mem_ready = e.rdy; fpu_done = e.done; exc_clear = e.clr;
         @(negedge clk);
         check("ctl", obs, e.exp);
         check("exc", exc_o, e.exc);
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic run(input logic [5:0] op, input logic [5:0] f, input int fw, input int mw, input int fn);
      instr_op = op; instr_funct = f;
      gen(op, f, fw, mw, fn);
      play(-1);
   endtask

   task automatic run_rand();
      logic [5:0] ops[9] = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd49, 6'd57, 6'd4, 6'd2, 6'd17};
      logic [5:0] fns[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
      int oi = $urandom_range(0, 9), fi = $urandom_range(0, 5);
      run(oi == 9 ? 6'($urandom_range(0, 63)) : ops[oi], fi == 5 ? 6'($urandom_range(0, 63)) : fns[fi],
          $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, tmo + 2));
   endtask

   initial begin
      mem_ready = 1'b1;
      @(negedge clk);
      check("rst_ctl", o1, 0);
      check("rst_state", st1, 0);
      check("rst_exc", exc1, 0);
      @(posedge clk); #1;
      rst1_n = 1'b1;
      run(6'b000000, 6'b100000, 0, 0, 0);
      run(6'b100011, 6'd0, 0, 3, 0);
      run(6'b010001, 6'd0, 0, 0, 5);
      run(6'b010001, 6'd0, 0, 0, 16);
      run(6'b010001, 6'd0, 0, 0, 17);
      force_clr = 1'b1;
      run(6'b000010, 6'd0, 0, 0, 0);
      run(6'b111111, 6'd0, 0, 0, 0);
      run(6'b000000, 6'b000111, 0, 0, 0);
      run(6'b000100, 6'd0, 0, 0, 0);
      run(6'b111001, 6'd0, 1, 2, 0);
      repeat (300) run_rand();
      run(6'b111111, 6'd0, 0, 0, 0);
      instr_op = 6'b101011;
      gen(6'b101011, 6'd0, 0, 2, 0);
      play(3);
      mem_ready = 1'b1;
      rst1_n = 1'b0;
      #1;
      check("rst_ctl_mw", o1, 0);
      check("rst_mw", o1[13], 0);
      check("rst_state_mw", st1, 0);
      check("rst_exc_mw", exc1, 0);
      q.delete();
      cause_m = 0;
      @(posedge clk); #1;
      rst1_n = 1'b1;
      #1;
      check("post_state", st1, 0);
      check("post_exc", exc1, 0);
      repeat (40) run_rand();
      rst1_n = 1'b0; sel = 1'b1; rst2_n = 1'b1;
      wen = 1'b0; fen = 1'b0; tmo = 3; cause_m = 0;
      run(6'b110001, 6'd0, 0, 0, 0);
      run(6'b111001, 6'd0, 0, 0, 0);
      run(6'b010001, 6'd0, 0, 0, 2);
      run(6'b100011, 6'd0, 2, 3, 0);
      run(6'b101011, 6'd0, 2, 3, 0);
      repeat (150) run_rand();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation main control for the MIPS core with FPU: a multi-cycle control FSM that replaces the single-cycle opcode decoder.
- Sequences fetch/decode/execute/memory/writeback per instruction, inserts memory wait states and waits on a multi-cycle FPU via a start/done handshake.
- Traps illegal opcodes, illegal functs and FPU timeouts to an exception vector.
- Sits between the instruction register and the datapath muxes, register files, ALU and FPU.

Parameters:
- MEM_WAIT_EN, 1, when 1, memory states stall until mem_ready=1; when 0, mem_ready is ignored and treated as 1.
- FP_EN, 1, when 0, opcodes 010001, 110001 and 111001 trap as illegal opcodes.
- FPU_TIMEOUT, 16, number of FP_WAIT cycles without fpu_done before a timeout trap; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_op  in  6  IR[31:26].
- instr_funct  in  6  IR[5:0].
- mem_ready  in  1  memory access completes this cycle.
- fpu_done  in  1  FPU result valid.
- exc_clear  in  1  clears exc_cause.
- pc_write, pc_write_cond, i_or_d, ir_write  out  1 each  PC/IR/address strobes.
- mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 reg, 01 const 4, 10 sign-extended imm.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- alu_ctl  out  3  ALU operation code.
- fpo  out  1  FP register file / FP path select.
- fpu_start  out  1  one-cycle FPU launch pulse.
- exc_cause  out  2  sticky cause: 00 none, 01 illegal opcode, 10 FPU timeout, 11 illegal funct.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: async on rst_n low. State = FETCH, exc_cause = 00, FPU counter = 0. All outputs are forced to 0 while rst_n=0. Reset mid-instruction abandons the instruction with no write strobes.
- Outputs are a Moore decode of state, except that memory strobes are gated by mem_ready as described below. Every output not listed for a state is 0.
- alu_ctl encoding:
  - 010 add: addi, lw, sw, lwc1, swc1, PC increment, funct 100000.
  - 110 sub: beq, funct 100010.
  - 000 and: funct 100100.
  - 001 or: funct 100101.
  - 111 slt: funct 101010.
- FETCH:
  - Asserts mem_read, alu_src_b=01, alu_ctl=010.
  - When mem_ready: ir_write=1, pc_write=1, pc_source=00, next state DECODE; otherwise stay in FETCH.
- DECODE:
  - Asserts alu_src_b=10, alu_ctl=010 (branch target).
  - Dispatch on instr_op:
    - 000000 -> R_EXEC if funct is supported, else TRAP with cause 11.
    - 001000 -> I_EXEC.
    - 100011/101011 -> MEM_ADDR.
    - 110001/111001 -> MEM_ADDR with fpo=1, only if FP_EN.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 010001 -> FP_EXEC, only if FP_EN.
    - Any other opcode -> TRAP with cause 01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctl=010. Next state is MEM_READ for loads, MEM_WRITE for stores.
- MEM_READ: i_or_d=1, mem_read=1. Advances to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- MEM_WRITE: i_or_d=1. mem_write=1 only in the cycle mem_ready=1, then FETCH.
- fpo is held at 1 for every state of lwc1, swc1 and FP R-type instructions.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctl decoded from funct. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_ctl=010. Next state I_WB.
- I_WB: reg_write=1, reg_dst=0, then FETCH.
- BRANCH: alu_src_a=1, alu_ctl=110, pc_write_cond=1, pc_source=01, then FETCH.
- JUMP: pc_write=1, pc_source=10, then FETCH.
- FP_EXEC: fpu_start=1 for exactly one cycle, counter cleared to 0, next state FP_WAIT.
- FP_WAIT:
  - fpu_done=1 -> FP_WB.
  - Else if counter == FPU_TIMEOUT-1 -> TRAP with cause 10.
  - Else counter increments.
  - fpu_done and timeout in the same cycle: done wins.
  - fpu_done is ignored in all other states.
- FP_WB: reg_write=1, reg_dst=1, fpo=1, then FETCH.
- TRAP: pc_write=1, pc_source=11; exc_cause loaded with the pending cause; next state FETCH.
- exc_cause is sticky. exc_clear=1 zeroes it on the next edge. A TRAP and exc_clear in the same cycle: the new cause wins.
- Zero-wait cycle counts:
  - beq, j: 3.
  - R-type, addi, sw, swc1: 4.
  - lw, lwc1: 5.
  - FP R-type: 4 + number of FP_WAIT cycles.
  - Trap: 3.

Test Plan:
- add (op 000000, funct 100000), mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; alu_ctl=010 in R_EXEC; reg_write=1 and reg_dst=1 in cycle 4 only.
- lw with mem_ready low for 3 cycles in MEM_READ, MEM_WAIT_EN=1 -> MEM_READ held 4 cycles; 8 cycles total; mem_to_reg=1 with reg_write=1 once.
- add.s (op 010001), fpu_done after 5 FP_WAIT cycles -> fpu_start pulses once; FP_WB with fpo=1, reg_write=1; 9 cycles total.
- add.s, fpu_done never asserted, FPU_TIMEOUT=16 -> 16 FP_WAIT cycles, then TRAP with pc_source=11, pc_write=1; exc_cause=10; exc_clear returns it to 00.
- Opcode 111111 -> TRAP after DECODE with exc_cause=01. With FP_EN=0, lwc1 also gives exc_cause=01. Funct 000111 gives exc_cause=11.
- rst_n asserted low during MEM_WRITE -> all outputs 0 immediately with no mem_write pulse; after release, state_dbg=FETCH and exc_cause=00.
